aes_decrypt_iterative: RTL and testbench
========================================

AES_DECRYPT_ITERATIVE -- requirements
Module: aes_decrypt_iterative

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port i_valid, input, 1 bit: ciphertext block offered.
REQ-004 SHALL have port o_ready, output, 1 bit: block can be accepted; combinational, equals (state==IDLE).
REQ-005 SHALL have port i_cipher_text, input, [0:127]: ciphertext; byte n = bits [8n:8n+7], column-major per FIPS-197.
REQ-006 SHALL have port i_key_schedule, input, [0:1407]: 11 expanded AES-128 round keys; round key k = bits [128k:128k+127].
REQ-007 SHALL have port o_valid, output, 1 bit: plaintext valid.
REQ-008 SHALL have port i_ready, input, 1 bit: downstream accepts plaintext.
REQ-009 SHALL have port o_plain_text, output, [0:127]: decrypted block, same byte order as REQ-005.

Function
REQ-010 SHALL implement the FIPS-197 AES-128 inverse cipher, iterative, one round per clock.
REQ-011 SHALL use FSM states IDLE, ROUND, DONE.
REQ-012 IDLE: on i_valid && o_ready, SHALL latch the key schedule, load state = i_cipher_text XOR round key 10, set round counter = 9, and go to ROUND.
REQ-013 ROUND, each cycle: state = InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), rk[cnt])), with InvMixColumns omitted when cnt==0; cnt decrements.
REQ-014 ROUND: when cnt==0 is processed, SHALL go to DONE, assert o_valid and drive the result on o_plain_text.
REQ-015 Latency: o_valid SHALL rise on the 11th rising edge after the accepting edge.
REQ-016 DONE: o_valid and o_plain_text SHALL hold stable until i_ready is high; on o_valid && i_ready, SHALL deassert o_valid and go to IDLE.
REQ-017 SHALL NOT accept a new block in the same cycle as an output handshake; minimum period is 12 cycles per block.
REQ-018 SHALL ignore changes on i_cipher_text and i_key_schedule outside IDLE; round keys SHALL come only from the latched copy.
REQ-019 SHALL ignore i_ready outside DONE and i_valid outside IDLE.
REQ-020 Round counter SHALL be 4 bits and SHALL never wrap below 0.

Reset
REQ-021 On rst_n low, SHALL immediately go to IDLE: o_valid=0, o_plain_text=0, counter=0, latched keys=0, so o_ready=1.
REQ-022 Reset during ROUND or DONE SHALL discard the in-flight block; no o_valid after reset release until a new accept.
REQ-023 After rst_n rises, SHALL accept a block on the first edge with i_valid high.

Configuration
REQ-024 Macro AES_DEC_BLK_CNT_EN: when defined, SHALL add output port o_blk_count [31:0] (reset 0), incremented on each output handshake and wrapping from 0xFFFFFFFF to 0.
REQ-025 Without AES_DEC_BLK_CNT_EN, SHALL omit the port and counter; all other behaviour is identical.

Verification
REQ-026 FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f expanded, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> o_plain_text 00112233445566778899aabbccddeeff, o_valid 11 edges after accept.
REQ-027 Backpressure: i_ready low for 5 cycles in DONE -> o_valid and data stable; o_ready=0 throughout; handshake on the 6th cycle, then IDLE.
REQ-028 Input change: i_cipher_text and i_key_schedule randomized every cycle during ROUND -> result still matches C.1.
REQ-029 Reset: rst_n pulsed low at round cnt=4 -> o_valid=0 and o_ready=1 at once; no spurious output afterwards; next block decrypts correctly.
REQ-030 Back-to-back: 3 blocks with i_valid and i_ready held high -> accepts exactly 12 cycles apart; all outputs correct.
REQ-031 With AES_DEC_BLK_CNT_EN: counter preloaded to 0xFFFFFFFF by forcing, one handshake -> o_blk_count=0.

Source files
------------

// File: rtl/aes_decrypt_iterative.sv
// ---------------------------------------------------------------------------
// aes_decrypt_iterative
//
// Iterative AES-128 inverse cipher, one decryption round per clock. A block
// is accepted in IDLE, run through ten inverse rounds in ROUND, then held in
// DONE until the downstream side takes it.
//
// Ports
//   clk             single clock, rising edge
//   rst_n           asynchronous active-low reset
//   i_valid         ciphertext block offered
//   o_ready         block can be accepted (high exactly in IDLE)
//   i_cipher_text   ciphertext, byte n = bits [8n:8n+7], column-major
//   i_key_schedule  11 expanded round keys, round key k = bits [128k:128k+127]
//   o_valid         plaintext valid (high exactly in DONE)
//   i_ready         downstream accepts plaintext
//   o_plain_text    decrypted block, same byte order as the ciphertext
//   o_blk_count     completed output handshakes (only with AES_DEC_BLK_CNT_EN)
//
// Optional feature macro: AES_DEC_BLK_CNT_EN adds the o_blk_count port and a
// free-running 32-bit handshake counter that wraps to zero.
// ---------------------------------------------------------------------------
module aes_decrypt_iterative (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [0:127]  i_cipher_text,
  input  logic [0:1407] i_key_schedule,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [0:127]  o_plain_text
`ifdef AES_DEC_BLK_CNT_EN
  ,
  output logic [31:0]   o_blk_count
`endif
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  // Inverse S-box, entry b at bits [8b:8b+7].
  localparam logic [0:2047] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant (used for 09, 0b, 0d, 0e).
  function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = b;
    for (int i = 0; i < 4; i++) begin
      if (k[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // One inverse round: InvShiftRows, InvSubBytes, AddRoundKey and, unless
  // this is the last round, InvMixColumns.
  function automatic logic [0:127] inv_round(input logic [0:127] s,
                                             input logic [0:127] rk,
                                             input logic         mix);
    logic [7:0]   t [0:15];
    logic [0:127] r;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++)
        t[row + 4*c] = s[8*(row + 4*((c - row + 4) % 4)) +: 8];
    for (int n = 0; n < 16; n++)
      r[8*n +: 8] = INV_SBOX[{t[n], 3'b000} +: 8] ^ rk[8*n +: 8];
    if (mix) begin
      for (int c = 0; c < 4; c++) begin
        a0 = r[32*c      +: 8];
        a1 = r[32*c + 8  +: 8];
        a2 = r[32*c + 16 +: 8];
        a3 = r[32*c + 24 +: 8];
        r[32*c      +: 8] = gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9);
        r[32*c + 8  +: 8] = gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd);
        r[32*c + 16 +: 8] = gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb);
        r[32*c + 24 +: 8] = gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he);
      end
    end
    return r;
  endfunction

  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [0:127] data_q, data_d;
  logic [0:127] rk_q [0:10];
  logic         load_keys;
  logic [0:127] round_key;
  logic [0:127] round_out;

  // Round key selection from the latched schedule; a compare chain keeps the
  // 4-bit counter from ever indexing past key 10.
  always_comb begin
    round_key = '0;
    for (int k = 0; k < 11; k++)
      if (cnt_q == 4'(k)) round_key = rk_q[k];
  end

  assign round_out = inv_round(data_q, round_key, cnt_q != 4'd0);

  // Next-state logic. The counter stops at zero; the cnt==0 round is the
  // last one and moves the block into DONE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    load_keys = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          state_d   = ROUND;
          cnt_d     = 4'd9;
          data_d    = i_cipher_text ^ i_key_schedule[1280 +: 128];
          load_keys = 1'b1;
        end
      end
      ROUND: begin
        data_d = round_out;
        if (cnt_q == 4'd0) state_d = DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      DONE: begin
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter, data path and key latch registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      data_q  <= '0;
      for (int k = 0; k < 11; k++) rk_q[k] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      if (load_keys)
        for (int k = 0; k < 11; k++) rk_q[k] <= i_key_schedule[128*k +: 128];
    end
  end

  assign o_ready      = (state_q == IDLE);
  assign o_valid      = (state_q == DONE);
  // Intermediate round values never reach the output port.
  assign o_plain_text = (state_q == DONE) ? data_q : '0;

`ifdef AES_DEC_BLK_CNT_EN
  logic [31:0] blk_count_q;

  // Completed output handshakes, wrapping naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 blk_count_q <= 32'd0;
    else if (o_valid && i_ready) blk_count_q <= blk_count_q + 32'd1;
  end

  assign o_blk_count = blk_count_q;
`endif

endmodule

// File: tb/tb_aes_decrypt_iterative.sv
// ---------------------------------------------------------------------------
// tb_aes_decrypt_iterative
//
// Bench for aes_decrypt_iterative. Expected plaintexts come from a forward
// AES cipher model built here from GF(2^8) arithmetic: a random plaintext is
// encrypted with a round-key schedule and the DUT must return it.
// With AES_DEC_BLK_CNT_EN defined the block counter is also exercised.
// ---------------------------------------------------------------------------
module tb_aes_decrypt_iterative;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_valid;
  logic          o_ready;
  logic [0:127]  i_cipher_text;
  logic [0:1407] i_key_schedule;
  logic          o_valid;
  logic          i_ready;
  logic [0:127]  o_plain_text;
`ifdef AES_DEC_BLK_CNT_EN
  logic [31:0]   o_blk_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] sbox [0:255];

  aes_decrypt_iterative dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_cipher_text (i_cipher_text),
    .i_key_schedule(i_key_schedule),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_plain_text  (o_plain_text)
`ifdef AES_DEC_BLK_CNT_EN
    ,
    .o_blk_count   (o_blk_count)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = xtime(a);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  // S-box = affine transform of the multiplicative inverse.
  function automatic void build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endfunction

  function automatic logic [0:1407] expand_key(input logic [0:127] key);
    logic [31:0]   w [0:43];
    logic [31:0]   tmp;
    logic [7:0]    rcon;
    logic [0:1407] ks;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp  = {tmp[23:0], tmp[31:24]};
        tmp  = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]} ^ {rcon, 24'h0};
        rcon = xtime(rcon);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 44; i++) ks[32*i +: 32] = w[i];
    return ks;
  endfunction

  function automatic logic [0:127] encrypt(input logic [0:127] pt, input logic [0:1407] ks);
    logic [7:0]   s [0:15];
    logic [7:0]   t [0:15];
    logic [7:0]   a0, a1, a2, a3;
    logic [0:127] res;
    for (int n = 0; n < 16; n++) s[n] = pt[8*n +: 8] ^ ks[8*n +: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int n = 0; n < 16; n++) t[n] = sbox[s[n]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          s[row + 4*c] = t[row + 4*((c + row) % 4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int n = 0; n < 16; n++) s[n] = s[n] ^ ks[128*r + 8*n +: 8];
    end
    for (int n = 0; n < 16; n++) res[8*n +: 8] = s[n];
    return res;
  endfunction

  function automatic logic [0:127] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [0:1407] rand1408();
    logic [0:1407] v;
    for (int i = 0; i < 44; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Offers one block and returns just after the accepting edge.
  task automatic applyStimulus(input logic [0:127] ct, input logic [0:1407] ks);
    int guard;
    guard = 0;
    while (!o_ready && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    check("accept_ready", 128'(o_ready), 128'(1));
    i_valid        = 1'b1;
    i_cipher_text  = ct;
    i_key_schedule = ks;
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  // Waits for o_valid (accept edge counted as edge 1, so o_valid must appear
  // on edge 11), optionally scrambling inputs meanwhile, stalls i_ready for
  // 'stall' cycles, then completes the handshake.
  task automatic checkOutput(input string tag, input logic [0:127] exp,
                             input bit scramble, input int stall);
    int edges;
    bit ready_seen;
    edges = 1;
    ready_seen = 1'b0;
    while (!o_valid && edges < 30) begin
      if (o_ready) ready_seen = 1'b1;
      if (scramble) begin
        i_cipher_text  = rand128();
        i_key_schedule = rand1408();
        i_valid        = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      edges++;
    end
    i_valid = 1'b0;
    check({tag, "_latency"}, 128'(edges), 128'(11));
    check({tag, "_busy_ready"}, 128'(ready_seen), 128'(0));
    check({tag, "_data"}, 128'(o_plain_text), 128'(exp));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check({tag, "_stall_valid"}, 128'(o_valid), 128'(1));
      check({tag, "_stall_data"}, 128'(o_plain_text), 128'(exp));
      check({tag, "_stall_ready"}, 128'(o_ready), 128'(0));
    end
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
    check({tag, "_hs_valid"}, 128'(o_valid), 128'(0));
    check({tag, "_hs_ready"}, 128'(o_ready), 128'(1));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [0:1407] c1_ks;
    logic [0:127]  pt, ct;
    logic [0:1407] ks;
    logic [0:127]  bb_pt [0:2];
    logic [0:127]  bb_ct [0:2];
    logic [0:1407] bb_ks [0:2];
    int            acc_cyc [0:2];
    int            n_in, n_out, cyc, spurious;
    bit            accepting;
    localparam logic [0:127] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] C1_PT  = 128'h00112233445566778899aabbccddeeff;

    rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_cipher_text = '0; i_key_schedule = '0;
    build_sbox();
    c1_ks = expand_key(C1_KEY);
    for (int i = 0; i < 3; i++) acc_cyc[i] = 0;

    // Reset state
    #2;
    check("reset_ready", 128'(o_ready), 128'(1));
    check("reset_valid", 128'(o_valid), 128'(0));
    check("reset_data", 128'(o_plain_text), 128'(0));
`ifdef AES_DEC_BLK_CNT_EN
    check("reset_blk_count", 128'(o_blk_count), 128'(0));
`endif
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // FIPS-197 C.1, offered immediately after reset release
    $display("[TB] FIPS-197 C.1 vector");
    applyStimulus(C1_CT, c1_ks);
    checkOutput("c1", C1_PT, 1'b0, 0);

    // Random blocks with arbitrary (non-expanded) round keys
    for (int b = 0; b < 3; b++) begin
      pt = rand128(); ks = rand1408();
      ct = encrypt(pt, ks);
      applyStimulus(ct, ks);
      checkOutput($sformatf("rand%0d", b), pt, 1'b0, 0);
    end

    // Backpressure: five stalled cycles in DONE
    $display("[TB] backpressure");
    applyStimulus(C1_CT, c1_ks);
    checkOutput("bp", C1_PT, 1'b0, 5);

    // Inputs churning while rounds run
    $display("[TB] input scramble during rounds");
    applyStimulus(C1_CT, c1_ks);
    checkOutput("scramble", C1_PT, 1'b1, 0);

    // Reset while the round counter is at 4
    $display("[TB] reset mid-flight");
    applyStimulus(C1_CT, c1_ks);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", 128'(o_valid), 128'(0));
    check("midrst_ready", 128'(o_ready), 128'(1));
    check("midrst_data", 128'(o_plain_text), 128'(0));
    #1 rst_n = 1'b1;
    spurious = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (o_valid) spurious++;
    end
    check("midrst_no_output", 128'(spurious), 128'(0));
    pt = rand128(); ks = expand_key(rand128());
    applyStimulus(encrypt(pt, ks), ks);
    checkOutput("post_rst", pt, 1'b0, 0);

    // Back-to-back with i_valid and i_ready held high
    $display("[TB] back-to-back");
    for (int b = 0; b < 3; b++) begin
      bb_pt[b] = rand128();
      bb_ks[b] = expand_key(rand128());
      bb_ct[b] = encrypt(bb_pt[b], bb_ks[b]);
    end
    i_valid = 1'b1; i_ready = 1'b1;
    i_cipher_text = bb_ct[0]; i_key_schedule = bb_ks[0];
    n_in = 0; n_out = 0; cyc = 0;
    while (n_out < 3 && cyc < 80) begin
      accepting = o_ready && i_valid;
      if (accepting) acc_cyc[n_in] = cyc;
      if (o_valid) begin
        check($sformatf("b2b_data%0d", n_out), 128'(o_plain_text), 128'(bb_pt[n_out]));
        n_out++;
      end
      @(posedge clk); #1;
      cyc++;
      if (accepting) begin
        n_in++;
        if (n_in < 3) begin
          i_cipher_text  = bb_ct[n_in];
          i_key_schedule = bb_ks[n_in];
        end else begin
          i_valid = 1'b0;
        end
      end
    end
    i_valid = 1'b0; i_ready = 1'b0;
    check("b2b_outputs", 128'(n_out), 128'(3));
    check("b2b_period01", 128'(acc_cyc[1] - acc_cyc[0]), 128'(12));
    check("b2b_period12", 128'(acc_cyc[2] - acc_cyc[1]), 128'(12));

`ifdef AES_DEC_BLK_CNT_EN
    // Counter wrap from all-ones
    $display("[TB] block counter wrap");
    #1 force dut.blk_count_q = 32'hFFFF_FFFF;
    #1 release dut.blk_count_q;
    applyStimulus(C1_CT, c1_ks);
    checkOutput("cnt_wrap_blk", C1_PT, 1'b0, 0);
    check("blk_count_wrap", 128'(o_blk_count), 128'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
